// File: rtl/xmss_hash_responder_if.sv
// Chain-hash request bus plus the single-block compression core handshake.
// The slave modport is the responder's view; master is the initiator/core side.
interface xmss_hash_responder_if;
    logic          start;
    logic [1023:0] data_in;
    logic          message_length;
    logic          store_intermediate;
    logic          continue_intermediate;
    logic [255:0]  data_out;
    logic          done;
    logic          busy;
    logic          core_start;
    logic [511:0]  core_block;
    logic [255:0]  core_iv;
    logic [255:0]  core_digest;
    logic          core_done;

    modport slave (
        input  start, data_in, message_length, store_intermediate, continue_intermediate,
        input  core_digest, core_done,
        output data_out, done, busy, core_start, core_block, core_iv
    );

    modport master (
        output start, data_in, message_length, store_intermediate, continue_intermediate,
        output core_digest, core_done,
        input  data_out, done, busy, core_start, core_block, core_iv
    );
endinterface

// File: rtl/xmss_hash_responder.sv
// Splits a 768/1024-bit request into padded SHA-256 blocks, sequences them through an
// external compression core, and keeps one saved post-block0 state for shared-prefix reuse.
module xmss_hash_responder #(
    parameter int unsigned  MSG_LEN_SHORT = 768,
    parameter int unsigned  MSG_LEN_LONG  = 1024,
    parameter logic [255:0] SHA_IV        =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
    input logic                  clk,
    input logic                  reset,
    xmss_hash_responder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StFinish} state_e;

    state_e        state_q, state_d;
    logic [1023:0] data_q, data_d;
    logic          long_q, long_d;
    logic          store_q, store_d;
    logic [1:0]    idx_q, idx_d;
    logic [511:0]  block_q, block_d;
    logic [255:0]  iv_q, iv_d;
    logic [255:0]  saved_q, saved_d;
    logic          saved_vld_q, saved_vld_d;
    logic [255:0]  dout_q, dout_d;
    logic [1:0]    last_idx;

    function automatic logic [511:0] sel_block(input logic [1023:0] d, input logic lng,
                                               input logic [1:0] idx);
        logic [511:0] blk;
        if (idx == 2'd0) begin
            blk = d[1023:512];
        end else if (idx == 2'd1) begin
            blk = lng ? d[511:0] : {d[511:256], 8'h80, 184'd0, 64'(MSG_LEN_SHORT)};
        end else begin
            blk = {8'h80, 440'd0, 64'(MSG_LEN_LONG)};
        end
        return blk;
    endfunction

    assign last_idx = long_q ? 2'd2 : 2'd1;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        long_d      = long_q;
        store_d     = store_q;
        idx_d       = idx_q;
        block_d     = block_q;
        iv_d        = iv_q;
        saved_d     = saved_q;
        saved_vld_d = saved_vld_q;
        dout_d      = dout_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    data_d  = bus.data_in;
                    long_d  = bus.message_length;
                    // Continue wins over store, even when nothing valid is saved.
                    store_d = bus.store_intermediate & ~bus.continue_intermediate;
                    if (bus.continue_intermediate && saved_vld_q) begin
                        idx_d = 2'd1;
                        iv_d  = saved_q;
                    end else begin
                        idx_d = 2'd0;
                        iv_d  = SHA_IV;
                    end
                    block_d = sel_block(bus.data_in, bus.message_length, idx_d);
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.core_done) begin
                    iv_d = bus.core_digest;
                    if (idx_q == 2'd0 && store_q) begin
                        saved_d     = bus.core_digest;
                        saved_vld_d = 1'b1;
                    end
                    if (idx_q == last_idx) begin
                        dout_d  = bus.core_digest;
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        block_d = sel_block(data_q, long_q, idx_q + 2'd1);
                        state_d = StIssue;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            data_q      <= '0;
            long_q      <= 1'b0;
            store_q     <= 1'b0;
            idx_q       <= 2'd0;
            block_q     <= '0;
            iv_q        <= '0;
            saved_q     <= '0;
            saved_vld_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            long_q      <= long_d;
            store_q     <= store_d;
            idx_q       <= idx_d;
            block_q     <= block_d;
            iv_q        <= iv_d;
            saved_q     <= saved_d;
            saved_vld_q <= saved_vld_d;
            dout_q      <= dout_d;
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.done       = (state_q == StFinish);
    assign bus.busy       = (state_q == StIssue) || (state_q == StWait);
    assign bus.core_start = (state_q == StIssue);
    assign bus.core_block = block_q;
    assign bus.core_iv    = iv_q;

endmodule

// File: tb/tb_xmss_hash_responder.sv
// Bench for xmss_hash_responder: behavioural SHA-256 core with random latency and a
// digest scoreboard fed from an independent full-message SHA-256 model.
module tb_xmss_hash_responder;

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    xmss_hash_responder_if bus ();

    xmss_hash_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic         model_done;
    logic         spur_done;
    logic [255:0] model_digest;
    assign bus.core_done   = model_done | spur_done;
    assign bus.core_digest = model_digest;

    int           n_starts;
    int           stab_bad;
    int           lat_lo = 1;
    int           lat_hi = 4;
    bit           core_busy;
    logic [255:0] first_iv;
    logic [511:0] last_blk;
    logic [255:0] exp_q[$];
    logic [255:0] last_exp;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Full-message reference: standard padding, chained from the IV.
    function automatic logic [255:0] sha_ref(input logic [1023:0] d, input logic ml);
        logic [1535:0] p;
        logic [255:0]  h;
        int            nb;
        if (ml) begin
            p = {d, 1'b1, 447'd0, 64'd1024};
            nb = 3;
        end else begin
            p = {d[1023:256], 1'b1, 191'd0, 64'd768, 512'd0};
            nb = 2;
        end
        h = IV;
        for (int i = 0; i < nb; i++) h = sha_compress(h, p[1535 - 512 * i -: 512]);
        return h;
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32 * i +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural compression core; tracks block/IV stability while a compression is pending.
    initial begin : core_model
        logic [511:0] blk;
        logic [255:0] iv;
        int           lat;
        bit           aborted;
        model_done = 1'b0;
        model_digest = '0;
        core_busy = 1'b0;
        n_starts = 0;
        stab_bad = 0;
        forever begin
            @(negedge clk);
            while (bus.core_start === 1'b1) begin
                core_busy = 1'b1;
                blk = bus.core_block;
                iv = bus.core_iv;
                if (n_starts == 0) first_iv = iv;
                n_starts++;
                last_blk = blk;
                lat = $urandom_range(lat_hi, lat_lo);
                aborted = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (reset === 1'b0) aborted = 1'b1;
                    if (!aborted && (bus.core_block !== blk || bus.core_iv !== iv)) stab_bad++;
                end
                model_digest = aborted ? {8{32'hdeadbeef}} : sha_compress(iv, blk);
                model_done = 1'b1;
                @(negedge clk);
                model_done = 1'b0;
                core_busy = 1'b0;
            end
        end
    end

    task automatic run_req(input string name, input logic [1023:0] d, input logic ml,
                           input logic st, input logic ct, input int exp_starts,
                           input logic [255:0] exp_iv, input bit spurious_start);
        logic [255:0] exp;
        bit           busy_bad;
        bit           got;
        exp_q.push_back(sha_ref(d, ml));
        @(negedge clk);
        n_starts = 0;
        stab_bad = 0;
        bus.data_in = d;
        bus.message_length = ml;
        bus.store_intermediate = st;
        bus.continue_intermediate = ct;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.data_in = ~d;
        bus.message_length = ~ml;
        bus.store_intermediate = 1'b0;
        bus.continue_intermediate = 1'b0;
        busy_bad = 1'b0;
        got = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            bus.start = (spurious_start && cyc == 1);
            @(negedge clk);
        end
        bus.start = 1'b0;
        exp = exp_q.pop_front();
        last_exp = exp;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s timeout: done never seen, required done within 3000 cycles", name);
            return;
        end
        tests++;
        if (bus.data_out !== exp) begin
            fails++;
            $display("FAIL %s digest: got %h required %h", name, bus.data_out, exp);
        end
        tests++;
        if (n_starts != exp_starts) begin
            fails++;
            $display("FAIL %s core_starts: got %0d required %0d", name, n_starts, exp_starts);
        end
        tests++;
        if (first_iv !== exp_iv) begin
            fails++;
            $display("FAIL %s first_iv: got %h required %h", name, first_iv, exp_iv);
        end
        tests++;
        if (busy_bad || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s busy_window: got low_before_done=%0d busy_at_done=%b required 0/0",
                     name, busy_bad, bus.busy);
        end
        tests++;
        if (stab_bad != 0) begin
            fails++;
            $display("FAIL %s core_stable: got %0d changes required 0", name, stab_bad);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0 || bus.data_out !== exp) begin
            fails++;
            $display("FAIL %s done_pulse_hold: got done=%b data_out=%h required 0 %h",
                     name, bus.done, bus.data_out, exp);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.core_start !== 1'b0 ||
            bus.data_out !== '0 || bus.core_block !== '0 || bus.core_iv !== '0) begin
            fails++;
            $display("FAIL %s: got done=%b busy=%b core_start=%b data_out=%h iv=%h blk_nz=%b required all 0",
                     name, bus.done, bus.busy, bus.core_start, bus.data_out, bus.core_iv,
                     |bus.core_block);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_state");
        reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("after_release");
    endtask

    task automatic test_short();
        run_req("short_zero", '0, 1'b0, 1'b0, 1'b0, 2, IV, 1'b0);
        tests++;
        if (last_blk[63:0] !== 64'd768) begin
            fails++;
            $display("FAIL short_len_field: got %0d required 768", last_blk[63:0]);
        end
    endtask

    task automatic test_store_continue();
        logic [1023:0] d1;
        logic [1023:0] d2;
        d1 = {{64{8'hA5}}, 512'd0};
        d2 = {{64{8'hA5}}, 512'd1};
        run_req("store_long", d1, 1'b1, 1'b1, 1'b0, 3, IV, 1'b0);
        run_req("continue_long", d2, 1'b1, 1'b0, 1'b1, 2, sha_compress(IV, d2[1023:512]), 1'b0);
        // Both flags set: continue is honoured and the saved state is left untouched.
        run_req("both_flags", d2, 1'b0, 1'b1, 1'b1, 1, sha_compress(IV, d2[1023:512]), 1'b0);
        run_req("continue_again", d2, 1'b1, 1'b0, 1'b1, 2, sha_compress(IV, d2[1023:512]), 1'b0);
    endtask

    task automatic test_continue_after_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_req("continue_no_saved", rand1024(), 1'b1, 1'b0, 1'b1, 3, IV, 1'b0);
    endtask

    task automatic test_spurious();
        bit bad;
        run_req("start_in_wait", rand1024(), 1'b0, 1'b0, 1'b0, 2, IV, 1'b1);
        n_starts = 0;
        bad = 1'b0;
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.core_start !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
                bus.data_out !== last_exp) bad = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (bad || n_starts != 0) begin
            fails++;
            $display("FAIL idle_core_done: got disturbed=%0d starts=%0d required 0 0", bad, n_starts);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        lat_lo = 5;
        lat_hi = 5;
        @(negedge clk);
        n_starts = 0;
        bus.data_in = rand1024() | 1024'd1;
        bus.message_length = 1'b1;
        bus.store_intermediate = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.store_intermediate = 1'b0;
        for (int cyc = 0; cyc < 2000 && n_starts < 2; cyc++) @(negedge clk);
        tests++;
        if (n_starts != 2 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_reach_block1: got starts=%0d busy=%b required 2 1", n_starts, bus.busy);
        end
        #1 reset = 1'b0;
        #1 check_zero_outputs("async_reset_mid");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        for (int cyc = 0; cyc < 200 && core_busy; cyc++) begin
            if (bus.done !== 1'b0 || bus.core_start !== 1'b0) saw_done = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (saw_done || core_busy) begin
            fails++;
            $display("FAIL stale_core_done: got activity=%0d core_pending=%0d required 0 0",
                     saw_done, core_busy);
        end
        run_req("continue_after_abort", rand1024(), 1'b1, 1'b0, 1'b1, 3, IV, 1'b0);
        run_req("short_after_abort", rand1024(), 1'b0, 1'b0, 1'b0, 2, IV, 1'b0);
        lat_lo = 1;
        lat_hi = 4;
    endtask

    task automatic test_random_latency();
        logic [1023:0] d;
        logic          ml;
        lat_lo = 1;
        lat_hi = 70;
        for (int i = 0; i < 5; i++) begin
            d = rand1024();
            ml = 1'($urandom_range(1, 0));
            run_req("rand_latency", d, ml, 1'b0, 1'b0, ml ? 3 : 2, IV, 1'b0);
        end
        lat_lo = 1;
        lat_hi = 4;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.data_in = '0;
        bus.message_length = 1'b0;
        bus.store_intermediate = 1'b0;
        bus.continue_intermediate = 1'b0;
        spur_done = 1'b0;
        last_exp = '0;
        test_reset();
        test_short();
        test_store_continue();
        test_continue_after_reset();
        test_spurious();
        test_reset_mid();
        test_random_latency();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xmss_hash_responder.md
Name: xmss_hash_responder

Overview:
- Responder side of the chain-hash request interface that WOTS chain generation drives (start, data_in, message_length, store_intermediate / continue_intermediate, done, data_out).
- Splits each request into SHA-256 message blocks, applies SHA-256 padding, and sequences them through a single-block compression core.
- Holds one saved intermediate state so that a request with a shared key prefix can skip its first block.
- Sits between a chain/tree initiator and a plain compression core.

Parameters:
- MSG_LEN_SHORT, 768: bit length of a short message (message_length=0).
- MSG_LEN_LONG, 1024: bit length of a long message (message_length=1).
- SHA_IV, 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19: standard initial hash value.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- data_in  in  1024  message; MSB-first; short messages use [1023:256].
- message_length  in  1  0 = 768-bit message, 1 = 1024-bit message.
- store_intermediate  in  1  save the state after block0 of this request.
- continue_intermediate  in  1  skip block0 and start from the saved state.
- data_out  out  256  digest; registered; held until the next accepted start.
- done  out  1  one-cycle pulse when data_out is valid.
- busy  out  1  high from the cycle after an accepted start until done.
- core_start  out  1  one-cycle pulse launching one compression.
- core_block  out  512  block to compress; stable from core_start until core_done.
- core_iv  out  256  chaining value input; stable from core_start until core_done.
- core_digest  in  256  compression result; valid when core_done=1.
- core_done  in  1  one-cycle completion pulse; core latency is arbitrary (>=1 cycle).

Behaviour:
- Reset (reset=0, async): state=IDLE; data_out=0, done=0, busy=0, core_start=0, core_block=0, core_iv=0. Saved intermediate register cleared and its valid flag cleared. A reset mid-operation abandons the request; a later core_done is ignored.
- IDLE: on start=1, latch data_in, message_length, store and continue flags.
  - Block count N: 2 if message_length=0, 3 if message_length=1.
  - If continue_intermediate=1 and the saved state is valid: H=saved state, begin at block index 1.
  - Otherwise: H=SHA_IV, begin at block index 0.
  - If both store and continue are 1, continue wins and no store occurs.
  - Go to ISSUE.
- Block contents:
  - block0 = data[1023:512].
  - Short message, block1 = {data[511:256], 8'h80, 184'd0, 64'd768}.
  - Long message, block1 = data[511:0]; block2 = {8'h80, 440'd0, 64'd1024}.
- ISSUE (1 cycle): core_start=1, core_block = current block, core_iv=H. Go to WAIT.
- WAIT: hold core_block and core_iv. On core_done:
  - H <= core_digest.
  - If the block index is 0 and store is latched, the saved state <= core_digest and its valid flag is set.
  - If this was the last block, go to FINISH; otherwise increment the index and go to ISSUE.
- FINISH (1 cycle): data_out <= H, done=1, busy=0. Return to IDLE.
- Latency from an accepted start to done = sum over blocks of (1 + core latency) + 1 cycle.
- start while busy is ignored, with no queueing.
- core_done outside WAIT is ignored.
- The saved state persists across requests until overwritten by a later store or cleared by reset.

Test Plan:
- Short request: ml=0, data_in=0, no store/continue → exactly 2 core_start pulses; the first has core_iv=SHA_IV; the second core_block ends in 64'd768; done pulses once and data_out = SHA-256 of 96 zero bytes (per software model).
- Store then continue: ml=1, store=1, data_in={512'hA5..A5, 512'h0} → 3 core_starts, digest matches software. Then ml=1, continue=1, data_in={512'hA5..A5, 512'h1} → 2 core_starts; the first core_iv equals the saved block0 result; digest equals software SHA-256 of the full 128 bytes.
- Continue immediately after reset (no valid saved state) → 3 core_starts starting from SHA_IV; digest is correct.
- start pulsed in WAIT and a spurious core_done in IDLE → no extra core_start, busy and data_out unchanged, a single done per accepted request.
- reset=0 asserted in WAIT of block1, then released → all outputs 0 asynchronously and the saved state is invalid; the next short request completes correctly in 2 blocks.
- Core latency randomised between 1 and 70 cycles → core_block and core_iv stable throughout each WAIT; busy high exactly from start+1 until done.
